pipelined_subtractor: RTL and testbench
=======================================

PIPELINED_SUBTRACTOR -- requirements
Module: pipelined_subtractor

Interface
REQ-001 Parameter A_WIDTH, default 4: width of input a, 2..64.
REQ-002 Parameter B_WIDTH, default 4: width of input b, 2..64.
REQ-003 Parameter A_IS_SIGNED, default "TRUE": "TRUE" means a is two's complement; any other value means a is unsigned.
REQ-004 Parameter B_IS_SIGNED, default "TRUE": "TRUE" means b is two's complement; any other value means b is unsigned.
REQ-005 Parameter STAGES, default 2: number of carry-chain segments and pipeline registers, 1..8.
REQ-006 Derived OUTPUT_WIDTH = max(A_WIDTH, B_WIDTH)+1; derived SEG = ceil((OUTPUT_WIDTH+1)/STAGES).
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 a  input  A_WIDTH  minuend.
REQ-010 b  input  B_WIDTH  subtrahend.
REQ-011 in_valid  input  1  a/b present this cycle.
REQ-012 in_ready  output  1  block accepts a/b this cycle.
REQ-013 c  output  OUTPUT_WIDTH  difference a-b, two's complement.
REQ-014 ovf  output  1  true difference does not fit c as signed OUTPUT_WIDTH.
REQ-015 out_valid  output  1  c/ovf valid.
REQ-016 out_ready  input  1  downstream accepts c/ovf this cycle.

Function
REQ-017 Sign- or zero-extension of a and b (per *_IS_SIGNED) to OUTPUT_WIDTH+1 bits; difference = a_ext + ~b_ext + 1, all arithmetic modulo 2^(OUTPUT_WIDTH+1).
REQ-018 Carry chain split into STAGES segments of SEG bits (last segment may be shorter), LSB first; segment k is resolved in pipeline stage k using the carry registered from stage k-1; initial carry-in = 1.
REQ-019 Unprocessed upper operand bits and completed lower result bits travel with the valid token through each stage register.
REQ-020 c = bits [OUTPUT_WIDTH-1:0] of the internal result; ovf = internal bit OUTPUT_WIDTH XOR internal bit OUTPUT_WIDTH-1.
REQ-021 Transfer in: in_valid & in_ready at a rising edge; transfer out: out_valid & out_ready at a rising edge.
REQ-022 Global advance enable adv = ~out_valid | out_ready; in_ready = adv (combinational, no dependence on in_valid).
REQ-023 When adv=1 every stage register loads its predecessor, stage-0 valid loads in_valid; when adv=0 all stage registers, valids, c, ovf hold.
REQ-024 Latency: a transfer in at edge N gives out_valid=1 with its result after edge N+STAGES-1 if adv stays 1 (visible in cycle N+STAGES... i.e. STAGES register stages).
REQ-025 Throughput one result per cycle with out_ready held 1; no bubbles inserted.
REQ-026 Results leave in acceptance order; none dropped or duplicated under any in_valid/out_ready pattern.
REQ-027 Bubbles (in_valid=0 while adv=1) propagate as valid=0 slots and are squeezed only by downstream stall, never reordered.
REQ-028 c and ovf stable while out_valid=1 and out_ready=0.
REQ-029 Simultaneous transfer in and out in one cycle: both complete, pipeline shifts by one.

Reset
REQ-030 rst=1 at a rising edge clears all stage valids, out_valid=0, c=0, ovf=0, internal carries=0.
REQ-031 rst overrides in_valid/out_ready in the same cycle; in-flight operations are discarded, not completed.
REQ-032 During rst=1, in_ready=1 is permitted but no transfer is recorded; first transfer is accepted at the first edge with rst=0.

Verification
REQ-033 8/8 signed, STAGES=3: a=0x80, b=0x7F, out_ready=1 -> after 3 edges c=9'h101 (-255), ovf=0, out_valid=1 for one cycle.
REQ-034 8/8 unsigned, STAGES=3: a=0x00, b=0xFF -> c=9'h101, ovf=0; a=0xFF, b=0x00 -> c=9'h0FF, ovf=0.
REQ-035 A unsigned, B signed, 8/8, STAGES=2: a=0xFF, b=0x80 -> c=9'h17F, ovf=1.
REQ-036 STAGES=4, 100 random back-to-back inputs, out_ready random 50% -> outputs in order, match reference model, c/ovf stable during stalls, in_ready=0 exactly when out_valid=1 & out_ready=0.
REQ-037 STAGES=3, three operations in flight, rst pulsed 1 cycle -> out_valid=0, c=0, ovf=0 next cycle; no stale result ever appears afterward.
REQ-038 STAGES=1, 4/4 signed: a=4'h7, b=4'h8 -> c=5'h0F, ovf=0, out_valid one edge after acceptance.

Source files
------------

// File: rtl/pipelined_subtractor.sv
// Pipelined two's-complement subtractor: c = a - b with overflow flag.
// The carry chain is cut into STAGES segments; each pipeline stage resolves
// one segment and forwards the remaining operand bits, the finished low
// result bits and the segment carry to the next stage. A single global
// advance enable stalls the whole pipeline when the output is held.
module pipelined_subtractor #(
  parameter int    A_WIDTH      = 4,
  parameter int    B_WIDTH      = 4,
  parameter string A_IS_SIGNED  = "TRUE",
  parameter string B_IS_SIGNED  = "TRUE",
  parameter int    STAGES       = 2,
  localparam int   OUTPUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [A_WIDTH-1:0]      a,
  input  logic [B_WIDTH-1:0]      b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] c,
  output logic                    ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Internal arithmetic width, segment width and padded width (whole segments)
  localparam int IW  = OUTPUT_WIDTH + 1;
  localparam int SEG = (IW + STAGES - 1) / STAGES;
  localparam int PW  = SEG * STAGES;

  localparam bit A_SGN = (A_IS_SIGNED == "TRUE");
  localparam bit B_SGN = (B_IS_SIGNED == "TRUE");

  logic              adv_s;
  logic [PW-1:0]     a_ext_s;
  logic [PW-1:0]     b_ext_s;
  logic [PW-1:0]     r_last_d_s;
  logic              ovf_q;

  // Stage registers flattened so a stage can read its predecessor by slice
  logic [STAGES*PW-1:0] x_all_s;
  logic [STAGES*PW-1:0] y_all_s;
  logic [STAGES*PW-1:0] r_all_s;
  logic [STAGES-1:0]    carry_all_s;
  logic [STAGES-1:0]    valid_all_s;

  // Bits above the segment boundary only pad to whole segments; they are
  // extended consistently and never reach c or ovf.
  assign a_ext_s = {{(PW-A_WIDTH){A_SGN & a[A_WIDTH-1]}}, a};
  assign b_ext_s = {{(PW-B_WIDTH){B_SGN & b[B_WIDTH-1]}}, b};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [PW-1:0] x_in_s;
    logic [PW-1:0] y_in_s;
    logic [PW-1:0] r_in_s;
    logic          cin_s;
    logic          vin_s;
    logic [SEG:0]  sum_s;
    logic [PW-1:0] r_d;
    logic          carry_d;
    logic [PW-1:0] x_q;
    logic [PW-1:0] y_q;
    logic [PW-1:0] r_q;
    logic          carry_q;
    logic          valid_q;

    if (k == 0) begin : g_head
      // Subtraction as a + ~b + 1: the +1 enters as the first carry-in
      assign x_in_s = a_ext_s;
      assign y_in_s = ~b_ext_s;
      assign r_in_s = {PW{1'b0}};
      assign cin_s  = 1'b1;
      assign vin_s  = in_valid;
    end else begin : g_body
      assign x_in_s = x_all_s[(k-1)*PW +: PW];
      assign y_in_s = y_all_s[(k-1)*PW +: PW];
      assign r_in_s = r_all_s[(k-1)*PW +: PW];
      assign cin_s  = carry_all_s[k-1];
      assign vin_s  = valid_all_s[k-1];
    end

    // Resolve this stage's carry-chain segment and merge it into the result
    always_comb begin
      sum_s = {1'b0, x_in_s[k*SEG +: SEG]} + {1'b0, y_in_s[k*SEG +: SEG]}
            + {{SEG{1'b0}}, cin_s};
      r_d   = r_in_s;
      r_d[k*SEG +: SEG] = sum_s[SEG-1:0];
      carry_d = sum_s[SEG];
    end

    // Stage register: loads on advance, holds on stall, clears on reset
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        x_q     <= {PW{1'b0}};
        y_q     <= {PW{1'b0}};
        r_q     <= {PW{1'b0}};
      end else if (adv_s) begin
        valid_q <= vin_s;
        carry_q <= carry_d;
        x_q     <= x_in_s;
        y_q     <= y_in_s;
        r_q     <= r_d;
      end else begin
        valid_q <= valid_q;
        carry_q <= carry_q;
        x_q     <= x_q;
        y_q     <= y_q;
        r_q     <= r_q;
      end
    end

    assign x_all_s[k*PW +: PW] = x_q;
    assign y_all_s[k*PW +: PW] = y_q;
    assign r_all_s[k*PW +: PW] = r_q;
    assign carry_all_s[k]      = carry_q;
    assign valid_all_s[k]      = valid_q;

    if (k == STAGES - 1) begin : g_tail
      assign r_last_d_s = r_d;
    end
  end

  // Overflow flag registered together with the final stage result
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv_s) begin
      ovf_q <= r_last_d_s[OUTPUT_WIDTH] ^ r_last_d_s[OUTPUT_WIDTH-1];
    end else begin
      ovf_q <= ovf_q;
    end
  end

  assign out_valid = valid_all_s[STAGES-1];
  assign adv_s     = ~out_valid | out_ready;
  assign in_ready  = adv_s;
  assign c         = r_all_s[(STAGES-1)*PW +: OUTPUT_WIDTH];
  assign ovf       = ovf_q;

  // Operand copies and padding bits left over after the last stage
  logic unused_s;
  assign unused_s = ^{x_all_s[(STAGES-1)*PW +: PW], y_all_s[(STAGES-1)*PW +: PW],
                      carry_all_s[STAGES-1],
                      r_all_s[(STAGES-1)*PW + OUTPUT_WIDTH +: PW - OUTPUT_WIDTH],
                      r_last_d_s};

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor: five configurations run side
// by side against a shared clock/reset, with an integer reference model and
// an in-order scoreboard per instance.
module tb_pipelined_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_r    [5];
  logic [7:0] b_r    [5];
  logic       iv_r   [5];
  logic       ordy_r [5];
  logic [8:0] c_w    [5];
  logic       ovf_w  [5];
  logic       ov_w   [5];
  logic       ir_w   [5];
  logic [4:0] c4_s;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    int         id;
    logic [9:0] exp;
  } sb_t;
  sb_t sb[$];

  logic       acc    [5];
  logic       hold_v [5];
  logic [9:0] hold_x [5];

  always #5 clk = ~clk;

  // id0: 8/8 signed S3, id1: 8/8 unsigned S3, id2: a unsigned b signed S2,
  // id3: 8/8 signed S4, id4: 4/4 signed S1
  pipelined_subtractor #(.A_WIDTH(8), .B_WIDTH(8), .A_IS_SIGNED("TRUE"),  .B_IS_SIGNED("TRUE"),  .STAGES(3)) u0 (
    .clk(clk), .rst(rst), .a(a_r[0]), .b(b_r[0]), .in_valid(iv_r[0]), .in_ready(ir_w[0]),
    .c(c_w[0]), .ovf(ovf_w[0]), .out_valid(ov_w[0]), .out_ready(ordy_r[0]));
  pipelined_subtractor #(.A_WIDTH(8), .B_WIDTH(8), .A_IS_SIGNED("FALSE"), .B_IS_SIGNED("FALSE"), .STAGES(3)) u1 (
    .clk(clk), .rst(rst), .a(a_r[1]), .b(b_r[1]), .in_valid(iv_r[1]), .in_ready(ir_w[1]),
    .c(c_w[1]), .ovf(ovf_w[1]), .out_valid(ov_w[1]), .out_ready(ordy_r[1]));
  pipelined_subtractor #(.A_WIDTH(8), .B_WIDTH(8), .A_IS_SIGNED("FALSE"), .B_IS_SIGNED("TRUE"),  .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .a(a_r[2]), .b(b_r[2]), .in_valid(iv_r[2]), .in_ready(ir_w[2]),
    .c(c_w[2]), .ovf(ovf_w[2]), .out_valid(ov_w[2]), .out_ready(ordy_r[2]));
  pipelined_subtractor #(.A_WIDTH(8), .B_WIDTH(8), .A_IS_SIGNED("TRUE"),  .B_IS_SIGNED("TRUE"),  .STAGES(4)) u3 (
    .clk(clk), .rst(rst), .a(a_r[3]), .b(b_r[3]), .in_valid(iv_r[3]), .in_ready(ir_w[3]),
    .c(c_w[3]), .ovf(ovf_w[3]), .out_valid(ov_w[3]), .out_ready(ordy_r[3]));
  pipelined_subtractor #(.A_WIDTH(4), .B_WIDTH(4), .A_IS_SIGNED("TRUE"),  .B_IS_SIGNED("TRUE"),  .STAGES(1)) u4 (
    .clk(clk), .rst(rst), .a(a_r[4][3:0]), .b(b_r[4][3:0]), .in_valid(iv_r[4]), .in_ready(ir_w[4]),
    .c(c4_s), .ovf(ovf_w[4]), .out_valid(ov_w[4]), .out_ready(ordy_r[4]));
  assign c_w[4] = {4'b0000, c4_s};

  // Reference: exact integer difference, then wrap to OUTPUT_WIDTH and range-check
  function automatic logic [9:0] model(int id, logic [7:0] a, logic [7:0] b);
    int aw, ow, av, bv, d, lo, hi;
    bit as, bs;
    logic [31:0] dv;
    logic [9:0] r;
    aw = (id == 4) ? 4 : 8;
    as = (id != 1) && (id != 2);
    bs = (id != 1);
    av = int'(a) & ((1 << aw) - 1);
    bv = int'(b) & ((1 << aw) - 1);
    if (as && av >= (1 << (aw - 1))) av = av - (1 << aw);
    if (bs && bv >= (1 << (aw - 1))) bv = bv - (1 << aw);
    d  = av - bv;
    ow = aw + 1;
    lo = -(1 << (ow - 1));
    hi = (1 << (ow - 1)) - 1;
    dv = d & ((1 << ow) - 1);
    r  = {(d < lo) || (d > hi), dv[8:0]};
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop(int i);
    logic       found;
    int         idx;
    logic [9:0] exp;
    found = 1'b0;
    idx   = 0;
    exp   = 10'd0;
    for (int j = 0; j < sb.size(); j++) begin
      if (!found && sb[j].id == i) begin
        found = 1'b1;
        idx   = j;
        exp   = sb[j].exp;
      end
    end
    chk($sformatf("expected_pending_u%0d", i), {31'd0, found}, 32'd1);
    if (found) begin
      chk($sformatf("result_u%0d", i), {22'd0, ovf_w[i], c_w[i]}, {22'd0, exp});
      sb.delete(idx);
    end
  endtask

  // One clock: check/scoreboard on the falling edge, return just after the rising edge
  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      acc[i] = 1'b0;
      if (rst) begin
        hold_v[i] = 1'b0;
      end else begin
        chk($sformatf("in_ready_u%0d", i), {31'd0, ir_w[i]}, {31'd0, !(ov_w[i] && !ordy_r[i])});
        if (hold_v[i])
          chk($sformatf("stall_hold_u%0d", i), {21'd0, ov_w[i], ovf_w[i], c_w[i]}, {21'd0, 1'b1, hold_x[i]});
        hold_v[i] = ov_w[i] && !ordy_r[i];
        hold_x[i] = {ovf_w[i], c_w[i]};
        if (ov_w[i] && ordy_r[i]) pop(i);
        if (iv_r[i] && ir_w[i]) begin
          sb.push_back('{id: i, exp: model(i, a_r[i], b_r[i])});
          acc[i] = 1'b1;
        end
      end
    end
    if (rst) sb.delete();
    @(posedge clk);
    #1;
  endtask

  // Single operation: check latency, value and single-cycle out_valid
  task automatic single(int id, logic [7:0] a, logic [7:0] b, int lat, logic [9:0] expv);
    int k;
    a_r[id]  = a;
    b_r[id]  = b;
    iv_r[id] = 1'b1;
    cyc();
    iv_r[id] = 1'b0;
    k = 1;
    while (!ov_w[id] && k < 20) begin
      cyc();
      k++;
    end
    chk($sformatf("latency_u%0d", id), k, lat);
    chk($sformatf("value_u%0d", id), {22'd0, ovf_w[id], c_w[id]}, {22'd0, expv});
    cyc();
    chk($sformatf("one_cycle_u%0d", id), {31'd0, ov_w[id]}, 32'd0);
  endtask

  initial begin
    int acc_cnt;
    int seen;
    int k;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_r[i] = 8'h00; b_r[i] = 8'h00; iv_r[i] = 1'b0; ordy_r[i] = 1'b1;
      hold_v[i] = 1'b0; hold_x[i] = 10'd0; acc[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    iv_r[0] = 1'b1;
    cyc();
    cyc();
    iv_r[0] = 1'b0;
    for (int i = 0; i < 5; i++)
      chk($sformatf("reset_state_u%0d", i), {21'd0, ov_w[i], ovf_w[i], c_w[i]}, 32'd0);
    rst = 1'b0;
    cyc();

    single(0, 8'h80, 8'h7F, 3, {1'b0, 9'h101});
    single(1, 8'h00, 8'hFF, 3, {1'b0, 9'h101});
    single(1, 8'hFF, 8'h00, 3, {1'b0, 9'h0FF});
    single(2, 8'hFF, 8'h80, 2, {1'b1, 9'h17F});
    single(4, 8'h07, 8'h08, 1, {1'b0, 9'h00F});

    // Back-to-back with out_ready high: accepted every cycle
    for (int n = 0; n < 10; n++) begin
      a_r[1]  = 8'($urandom);
      b_r[1]  = 8'($urandom);
      iv_r[1] = 1'b1;
      cyc();
      chk("throughput_u1", {31'd0, acc[1]}, 32'd1);
    end
    iv_r[1] = 1'b0;
    for (int n = 0; n < 5; n++) cyc();

    // Three in flight with output stalled, then reset discards them
    ordy_r[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      a_r[0]  = 8'($urandom);
      b_r[0]  = 8'($urandom);
      iv_r[0] = 1'b1;
      cyc();
      chk("fill_accept_u0", {31'd0, acc[0]}, 32'd1);
    end
    iv_r[0] = 1'b0;
    cyc();
    chk("stalled_valid_u0", {31'd0, ov_w[0]}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("post_reset_u0", {21'd0, ov_w[0], ovf_w[0], c_w[0]}, 32'd0);
    ordy_r[0] = 1'b1;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      cyc();
      if (ov_w[0]) seen++;
    end
    chk("no_stale_u0", seen, 0);

    // Random traffic on all instances; id3 offers a new operand every cycle
    acc_cnt = 0;
    for (int n = 0; n < 600 && acc_cnt < 100; n++) begin
      for (int i = 0; i < 5; i++) begin
        a_r[i]    = 8'($urandom);
        b_r[i]    = 8'($urandom);
        iv_r[i]   = (i == 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        ordy_r[i] = 1'($urandom_range(0, 1));
      end
      cyc();
      if (acc[3]) acc_cnt++;
    end
    chk("random_accepts_u3", acc_cnt, 100);

    // Drain everything still in flight
    for (int i = 0; i < 5; i++) begin
      iv_r[i]   = 1'b0;
      ordy_r[i] = 1'b1;
    end
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      cyc();
      k++;
    end
    cyc();
    chk("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
